// File: rtl/aes_job_scheduler_pkg.sv
// Shared types for the AES job scheduler: FSM encoding, command word width
// and the requester-index width helper.
package aes_job_scheduler_pkg;

   localparam int WORD_S = 32;

   typedef enum logic [1:0] {
      AES_SCHED_IDLE  = 2'd0,
      AES_SCHED_START = 2'd1,
      AES_SCHED_WAIT  = 2'd2,
      AES_SCHED_DONE  = 2'd3
   } sched_state_e;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin search: first set request at or above the
// pointer, wrapping from NUM_REQ-1 back to 0.
module aes_rr_arbiter
   import aes_job_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int SEL_W   = sel_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid_i,
   input  logic [SEL_W-1:0]   rr_ptr_i,
   output logic [SEL_W-1:0]   winner_o,
   output logic               any_valid_o
);

   int   idx;
   logic found;

   always_comb begin
      winner_o = '0;
      found    = 1'b0;
      idx      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (32'(rr_ptr_i) + i) % NUM_REQ;
         if (!found && req_valid_i[idx]) begin
            found    = 1'b1;
            winner_o = SEL_W'(idx);
         end
      end
   end

   assign any_valid_o = |req_valid_i;

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one aes_controller between NUM_REQ requesters, one job at a time.
// Optional WAIT watchdog is built when AES_SCHED_TIMEOUT_EN is defined.
module aes_job_scheduler
   import aes_job_scheduler_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int CMD_WIDTH      = WORD_S,
   parameter int BLK_CNT_WIDTH  = 9,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int SEL_W          = sel_width(NUM_REQ)
) (
   input  logic                             s00_axis_aclk,
   input  logic                             s00_axis_aresetn,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*CMD_WIDTH-1:0]     req_cmd,
   input  logic [NUM_REQ*BLK_CNT_WIDTH-1:0] req_blk_cnt,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic [NUM_REQ-1:0]               req_done,
   output logic [NUM_REQ-1:0]               req_err,
   output logic                             ctrl_en,
   output logic [CMD_WIDTH-1:0]             ctrl_cmd,
   output logic [BLK_CNT_WIDTH-1:0]         ctrl_blk_cnt,
   output logic [SEL_W-1:0]                 ctrl_sel,
   input  logic                             ctrl_done,
   output logic                             ctrl_abort,
   output logic                             busy
);

   sched_state_e             state_q, state_d;
   logic [CMD_WIDTH-1:0]     cmd_q, cmd_d;
   logic [BLK_CNT_WIDTH-1:0] blk_q, blk_d;
   logic [SEL_W-1:0]         sel_q, sel_d;
   logic [SEL_W-1:0]         rr_q, rr_d;
   logic                     zero_q, zero_d;
   logic                     en_q, en_d;
   logic                     busy_q;
   logic [NUM_REQ-1:0]       ready_q, ready_d;
   logic [NUM_REQ-1:0]       done_q, done_d;

   logic [SEL_W-1:0]         win;
   logic                     any_vld;
   logic [SEL_W-1:0]         sel_nxt;
   logic [CMD_WIDTH-1:0]     win_cmd;
   logic [BLK_CNT_WIDTH-1:0] win_blk;

   aes_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .SEL_W   (SEL_W)
   ) u_arb (
      .req_valid_i (req_valid),
      .rr_ptr_i    (rr_q),
      .winner_o    (win),
      .any_valid_o (any_vld)
   );

   assign win_cmd = req_cmd[32'(win)*CMD_WIDTH +: CMD_WIDTH];
   assign win_blk = req_blk_cnt[32'(win)*BLK_CNT_WIDTH +: BLK_CNT_WIDTH];
   assign sel_nxt = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;

`ifdef AES_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               abort_q, abort_d;
   logic [NUM_REQ-1:0] err_q, err_d;
   logic               to_hit;

   assign to_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (en_d) begin
         cnt_d = '0;
      end else if (state_q == AES_SCHED_WAIT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         cnt_q   <= '0;
         abort_q <= 1'b0;
         err_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
         err_q   <= err_d;
      end
   end

   assign ctrl_abort = abort_q;
   assign req_err    = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES > 0);
   assign ctrl_abort     = 1'b0;
   assign req_err        = '0;
`endif

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      blk_d   = blk_q;
      sel_d   = sel_q;
      rr_d    = rr_q;
      zero_d  = zero_q;
      ready_d = '0;
      done_d  = '0;
      en_d    = 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
      abort_d = 1'b0;
      err_d   = '0;
`endif
      unique case (state_q)
         AES_SCHED_IDLE: begin
            if (any_vld) begin
               cmd_d        = win_cmd;
               blk_d        = win_blk;
               sel_d        = win;
               zero_d       = (win_blk == '0);
               ready_d[win] = 1'b1;
               state_d      = (win_blk == '0) ? AES_SCHED_DONE
                                              : AES_SCHED_START;
            end
         end
         AES_SCHED_START: begin
            en_d    = 1'b1;
            state_d = AES_SCHED_WAIT;
         end
         AES_SCHED_WAIT: begin
            if (ctrl_done) begin
               done_d[sel_q] = 1'b1;
               state_d       = AES_SCHED_DONE;
            end
`ifdef AES_SCHED_TIMEOUT_EN
            else if (to_hit) begin
               abort_d      = 1'b1;
               err_d[sel_q] = 1'b1;
               rr_d         = sel_nxt;
               state_d      = AES_SCHED_IDLE;
            end
`endif
         end
         AES_SCHED_DONE: begin
            // Zero-length jobs skip WAIT, so their completion fires here.
            if (zero_q) begin
               done_d[sel_q] = 1'b1;
            end
            rr_d    = sel_nxt;
            state_d = AES_SCHED_IDLE;
         end
         default: state_d = AES_SCHED_IDLE;
      endcase
   end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         state_q <= AES_SCHED_IDLE;
         cmd_q   <= '0;
         blk_q   <= '0;
         sel_q   <= '0;
         rr_q    <= '0;
         zero_q  <= 1'b0;
         ready_q <= '0;
         done_q  <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         blk_q   <= blk_d;
         sel_q   <= sel_d;
         rr_q    <= rr_d;
         zero_q  <= zero_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         en_q    <= en_d;
         busy_q  <= (state_d != AES_SCHED_IDLE);
      end
   end

   assign req_ready    = ready_q;
   assign req_done     = done_q;
   assign ctrl_en      = en_q;
   assign ctrl_cmd     = cmd_q;
   assign ctrl_blk_cnt = blk_q;
   assign ctrl_sel     = sel_q;
   assign busy         = busy_q;

endmodule
